gam_node_memory: RTL and testbench

- Parametrised, handshaked successor to the GAM memory layer.
- Stores per-class node records: input vector X, weight vector W, threshold Th and match counter M.
- Adds dynamic node allocation ("growing" memory), per-class node counts, atomic M increment, class clear, and error reporting.
- Sits between the GAM learning/recall controller and the node storage; one request in flight at a time.

---
 rtl/gam_node_memory_if.sv | 39 +++
 rtl/gam_node_memory.sv | 106 ++++++++++
 tb/tb_gam_node_memory.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gam_node_memory_if.sv
// gam_node_memory_if: request/response bus between the GAM controller and the node memory
interface gam_node_memory_if #(
   parameter int NUM_CLASSES = 4,
   parameter int NODES_PER_CLASS = 16,
   parameter int VEC_LEN = 8,
   parameter int ELEM_W = 16,
   parameter int TH_W = 32,
   parameter int M_W = 32
);
   localparam int CW = $clog2(NUM_CLASSES);
   localparam int NW = $clog2(NODES_PER_CLASS);
   localparam int VW = VEC_LEN * ELEM_W;
   logic req_valid;
   logic req_ready;
   logic [2:0] req_op;
   logic [CW:0] req_class;
   logic [NW:0] req_node;
   logic [3:0] fld_en;
   logic [VW-1:0] wr_X;
   logic [VW-1:0] wr_W;
   logic [TH_W-1:0] wr_Th;
   logic [M_W-1:0] wr_M;
   logic rsp_valid;
   logic rsp_err;
   logic [NW-1:0] rsp_node;
   logic [VW-1:0] rsp_X;
   logic [VW-1:0] rsp_W;
   logic [TH_W-1:0] rsp_Th;
   logic [M_W-1:0] rsp_M;
   logic [(NW+1)*NUM_CLASSES-1:0] count_o;
   modport master (
      output req_valid, req_op, req_class, req_node, fld_en, wr_X, wr_W, wr_Th, wr_M,
      input req_ready, rsp_valid, rsp_err, rsp_node, rsp_X, rsp_W, rsp_Th, rsp_M, count_o
   );
   modport slave (
      input req_valid, req_op, req_class, req_node, fld_en, wr_X, wr_W, wr_Th, wr_M,
      output req_ready, rsp_valid, rsp_err, rsp_node, rsp_X, rsp_W, rsp_Th, rsp_M, count_o
   );
endinterface

// File: rtl/gam_node_memory.sv
// gam_node_memory: per-class growing node store (X, W, Th, M) with read/write/alloc/inc/clear
module gam_node_memory #(
   parameter int NUM_CLASSES = 4,
   parameter int NODES_PER_CLASS = 16,
   parameter int VEC_LEN = 8,
   parameter int ELEM_W = 16,
   parameter int TH_W = 32,
   parameter int M_W = 32
) (
   input logic clk,
   input logic rst,
   gam_node_memory_if.slave bus
);
   localparam int CW = $clog2(NUM_CLASSES);
   localparam int NW = $clog2(NODES_PER_CLASS);
   localparam int VW = VEC_LEN * ELEM_W;
   localparam logic [2:0] OP_WRITE = 3'd1, OP_ALLOC = 3'd2, OP_INC = 3'd3, OP_CLR = 3'd4;
   localparam logic [1:0] IDLE = 2'd0, RESP = 2'd1, RMW = 2'd2, CLEAR = 2'd3;
   localparam logic [CW:0] NC = (CW+1)'(NUM_CLASSES);
   localparam logic [NW:0] NPC = (NW+1)'(NODES_PER_CLASS);
   localparam logic [NW-1:0] LAST = NW'(NODES_PER_CLASS - 1);
   logic [VW-1:0] x_mem [NUM_CLASSES][NODES_PER_CLASS];
   logic [VW-1:0] w_mem [NUM_CLASSES][NODES_PER_CLASS];
   logic [TH_W-1:0] th_mem [NUM_CLASSES][NODES_PER_CLASS];
   logic [M_W-1:0] m_mem [NUM_CLASSES][NODES_PER_CLASS];
   logic [NW:0] cnt [NUM_CLASSES];
   logic [1:0] state;
   logic [2:0] op;
   logic [CW-1:0] cls, rc;
   logic [NW-1:0] node, walk, rn;
   logic [NW:0] cur;
   logic [M_W-1:0] m_cur;
   logic err, acc, bad, show;
   assign rc = bus.req_class[CW-1:0];
   assign rn = bus.req_node[NW-1:0];
   assign cur = cnt[rc];
   assign acc = bus.req_valid && bus.req_ready;
   // ALLOC only fails on a full class; CLEAR never checks the node; the rest need an allocated node
   assign bad = bus.req_class >= NC || bus.req_op > OP_CLR ||
                (bus.req_op == OP_ALLOC ? cur == NPC : bus.req_op != OP_CLR && bus.req_node >= cur);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op <= '0;
         cls <= '0;
         node <= '0;
         walk <= '0;
         err <= 1'b0;
         for (int k = 0; k < NUM_CLASSES; k++) cnt[k] <= '0;
      end else begin
         case (state)
            IDLE: if (acc) begin
               state <= bad ? RESP : bus.req_op == OP_INC ? RMW : bus.req_op == OP_CLR ? CLEAR : RESP;
               op <= bus.req_op;
               cls <= rc;
               err <= bad;
               walk <= '0;
               node <= bus.req_op == OP_ALLOC ? cur[NW-1:0] : rn;
               if (!bad && bus.req_op == OP_ALLOC) cnt[rc] <= cur + 1'b1;
               if (!bad && bus.req_op == OP_CLR) cnt[rc] <= '0;
            end
            RMW: state <= RESP;
            CLEAR: begin
               walk <= walk + 1'b1;
               if (walk == LAST) state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Storage has no reset; reset only suppresses writes so an aborted walk stops immediately
   always_ff @(posedge clk) begin
      if (!rst && acc && !bad && bus.req_op == OP_WRITE) begin
         if (bus.fld_en[0]) x_mem[rc][rn] <= bus.wr_X;
         if (bus.fld_en[1]) w_mem[rc][rn] <= bus.wr_W;
         if (bus.fld_en[2]) th_mem[rc][rn] <= bus.wr_Th;
         if (bus.fld_en[3]) m_mem[rc][rn] <= bus.wr_M;
      end
      if (!rst && acc && !bad && bus.req_op == OP_ALLOC) begin
         x_mem[rc][cur[NW-1:0]] <= bus.fld_en[0] ? bus.wr_X : '0;
         w_mem[rc][cur[NW-1:0]] <= bus.fld_en[1] ? bus.wr_W : '0;
         th_mem[rc][cur[NW-1:0]] <= bus.fld_en[2] ? bus.wr_Th : '0;
         m_mem[rc][cur[NW-1:0]] <= bus.fld_en[3] ? bus.wr_M : '0;
      end
      if (!rst && state == RMW) m_mem[cls][node] <= &m_cur ? m_cur : m_cur + 1'b1;
      if (!rst && state == CLEAR) begin
         x_mem[cls][walk] <= '0;
         w_mem[cls][walk] <= '0;
         th_mem[cls][walk] <= '0;
         m_mem[cls][walk] <= '0;
      end
   end
   assign m_cur = m_mem[cls][node];
   assign show = state == RESP && !err && op != OP_CLR;
   assign bus.req_ready = state == IDLE;
   assign bus.rsp_valid = state == RESP;
   assign bus.rsp_err = state == RESP && err;
   assign bus.rsp_node = show ? node : '0;
   assign bus.rsp_X = show ? x_mem[cls][node] : '0;
   assign bus.rsp_W = show ? w_mem[cls][node] : '0;
   assign bus.rsp_Th = show ? th_mem[cls][node] : '0;
   assign bus.rsp_M = show ? m_cur : '0;
   for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
      assign bus.count_o[i*(NW+1) +: NW+1] = cnt[i];
   end
endmodule

// File: tb/tb_gam_node_memory.sv
// tb_gam_node_memory: directed plus random transactions checked against an array model of the node store
module tb_gam_node_memory;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [127:0] mx [4][16];
   logic [127:0] mw [4][16];
   logic [31:0] mth [4][16];
   logic [31:0] mm [4][16];
   int cnt [4];
   gam_node_memory_if bus ();
   gam_node_memory dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [19:0] exp_count();
      logic [19:0] r;
      for (int i = 0; i < 4; i++) r[i*5 +: 5] = 5'(cnt[i]);
      return r;
   endfunction
   function automatic logic [127:0] r128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction
   task automatic issue(input logic [2:0] op, input int c, input int n, input logic [3:0] fen,
                        input logic [127:0] x, input logic [127:0] w, input logic [31:0] th, input logic [31:0] m);
      int k = 0;
      while (!bus.req_ready && k < 50) begin
         step();
         k++;
      end
      chk("ready_wait", 128'(bus.req_ready), 128'(1));
      bus.req_op = op;
      bus.req_class = 3'(c);
      bus.req_node = 5'(n);
      bus.fld_en = fen;
      bus.wr_X = x;
      bus.wr_W = w;
      bus.wr_Th = th;
      bus.wr_M = m;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
   endtask
   task automatic run(input logic [2:0] op, input int c, input int n, input logic [3:0] fen,
                      input logic [127:0] x, input logic [127:0] w, input logic [31:0] th, input logic [31:0] m);
      logic e, busy;
      int en, lat, elat, cc;
      cc = (c >= 0 && c < 4) ? cnt[c] : 0;
      e = c >= 4 || op > 3'd4 || (op == 3'd2 && cc == 16) || ((op == 3'd0 || op == 3'd1 || op == 3'd3) && n >= cc);
      en = n;
      elat = e ? 1 : op == 3'd3 ? 2 : op == 3'd4 ? 17 : 1;
      if (!e) begin
         if (op == 3'd1) begin
            if (fen[0]) mx[c][n] = x;
            if (fen[1]) mw[c][n] = w;
            if (fen[2]) mth[c][n] = th;
            if (fen[3]) mm[c][n] = m;
         end
         if (op == 3'd2) begin
            en = cc;
            mx[c][en] = fen[0] ? x : '0;
            mw[c][en] = fen[1] ? w : '0;
            mth[c][en] = fen[2] ? th : '0;
            mm[c][en] = fen[3] ? m : '0;
            cnt[c]++;
         end
         if (op == 3'd3 && mm[c][n] != 32'hFFFF_FFFF) mm[c][n] = mm[c][n] + 1;
         if (op == 3'd4) cnt[c] = 0;
      end
      issue(op, c, n, fen, x, w, th, m);
      lat = 1;
      busy = 1'b0;
      while (!bus.rsp_valid && lat < 40) begin
         busy |= bus.req_ready;
         step();
         lat++;
      end
      chk("latency", 128'(lat), 128'(elat));
      chk("ready_while_busy", 128'(busy), 128'(0));
      chk("rsp_err", 128'(bus.rsp_err), 128'(e));
      chk("count_o", 128'(bus.count_o), 128'(exp_count()));
      if (e) begin
         chk("err_X", bus.rsp_X, '0);
         chk("err_W", bus.rsp_W, '0);
         chk("err_Th", 128'(bus.rsp_Th), '0);
         chk("err_M", 128'(bus.rsp_M), '0);
      end else if (op <= 3'd2) begin
         chk("rsp_node", 128'(bus.rsp_node), 128'(en));
         chk("rsp_X", bus.rsp_X, mx[c][en]);
         chk("rsp_W", bus.rsp_W, mw[c][en]);
         chk("rsp_Th", 128'(bus.rsp_Th), 128'(mth[c][en]));
         chk("rsp_M", 128'(bus.rsp_M), 128'(mm[c][en]));
      end else if (op == 3'd3) begin
         chk("inc_M", 128'(bus.rsp_M), 128'(mm[c][n]));
      end
      step();
      chk("one_shot", 128'(bus.rsp_valid), 128'(0));
   endtask
   initial begin
      logic [127:0] x1, w1;
      logic seen;
      int r, c, n;
      logic [2:0] op;
      bus.req_valid = 1'b0;
      bus.req_op = '0;
      bus.req_class = '0;
      bus.req_node = '0;
      bus.fld_en = '0;
      bus.wr_X = '0;
      bus.wr_W = '0;
      bus.wr_Th = '0;
      bus.wr_M = '0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_ready", 128'(bus.req_ready), 128'(1));
      chk("reset_valid", 128'(bus.rsp_valid), 128'(0));
      chk("reset_count", 128'(bus.count_o), '0);
      chk("reset_M", 128'(bus.rsp_M), '0);
      run(3'd0, 0, 0, 4'b0000, '0, '0, '0, '0);
      x1 = r128();
      w1 = r128();
      run(3'd2, 1, 0, 4'b1111, x1, w1, 32'd100, 32'd5);
      run(3'd0, 1, 0, 4'b0000, '0, '0, '0, '0);
      chk("alloc_Th", 128'(bus.rsp_Th), 128'(0));
      for (int i = 0; i < 17; i++) run(3'd2, 2, 0, 4'($urandom_range(0, 15)), r128(), r128(), $urandom(), $urandom());
      run(3'd1, 1, 0, 4'b0010, r128(), r128(), 32'd7, 32'd9);
      run(3'd0, 1, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd1, 1, 0, 4'b1000, '0, '0, '0, 32'hFFFF_FFFE);
      run(3'd3, 1, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd3, 1, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd0, 1, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd4, 2, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd0, 2, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd5, 0, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd0, 4, 0, 4'b0000, '0, '0, '0, '0);
      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 19);
         op = r < 7 ? 3'd2 : r < 11 ? 3'd0 : r < 14 ? 3'd1 : r < 17 ? 3'd3 : r < 18 ? 3'd4 : 3'($urandom_range(5, 7));
         c = $urandom_range(0, 4);
         n = $urandom_range(0, 16);
         run(op, c, n, 4'($urandom_range(0, 15)), r128(), r128(), $urandom(), $urandom());
      end
      run(3'd2, 2, 0, 4'b1111, r128(), r128(), $urandom(), $urandom());
      run(3'd2, 2, 0, 4'b1111, r128(), r128(), $urandom(), $urandom());
      issue(3'd4, 2, 0, 4'b0000, '0, '0, '0, '0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen |= bus.rsp_valid | bus.req_ready;
         step();
      end
      rst = 1'b1;
      seen |= bus.rsp_valid;
      step();
      rst = 1'b0;
      chk("midwalk_busy", 128'(seen), 128'(0));
      chk("rst_ready", 128'(bus.req_ready), 128'(1));
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      chk("rst_count", 128'(bus.count_o), 128'(exp_count()));
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         seen |= bus.rsp_valid;
         step();
      end
      chk("no_rsp_after_abort", 128'(seen), 128'(0));
      run(3'd0, 1, 0, 4'b0000, '0, '0, '0, '0);
      run(3'd2, 2, 0, 4'b0101, r128(), r128(), $urandom(), $urandom());
      run(3'd0, 2, 0, 4'b0000, '0, '0, '0, '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
